cont_multidigito: RTL

Parametrised multi-digit up/down counter with a built-in prescaler and a per-digit seven-segment decoder, for FPGA board displays. It replaces the separate single-digit counter, frequency divider and hex-to-segment converter with one synchronous block on the board clock. It counts in hex or BCD across any number of digits, with enable, parallel load and wrap/borrow flagging. Segment outputs drive active-low displays directly.

---
 rtl/cont_multidigito.sv | 111 +++++++++++
 1 files changed

// File: rtl/cont_multidigito.sv
// Multi-digit hex/BCD up/down counter with prescaler, parallel load,
// wrap/borrow flag and registered active-low seven-segment outputs.
module cont_multidigito #(
  parameter int DIGITS = 4,
  parameter int DIV    = 5000000,
  parameter int RADIX  = 16
) (
  input  logic                  ck,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  updown,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tick,
  output logic                  carry,
  output logic [7*DIGITS-1:0]   seg
);

  localparam int unsigned      ND       = DIGITS;
  localparam int               PW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]    PRE_LAST = PW'(DIV - 1);
  localparam logic [3:0]       DIG_MAX  = 4'(RADIX - 1);

  logic [PW-1:0]         pre;
  logic                  step;
  logic                  wrap;
  logic [4*DIGITS-1:0]   count_nxt;
  logic [4*DIGITS-1:0]   load_fix;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] on;
    case (d)
      4'h0: on = 7'b0111111;
      4'h1: on = 7'b0000110;
      4'h2: on = 7'b1011011;
      4'h3: on = 7'b1001111;
      4'h4: on = 7'b1100110;
      4'h5: on = 7'b1101101;
      4'h6: on = 7'b1111101;
      4'h7: on = 7'b0000111;
      4'h8: on = 7'b1111111;
      4'h9: on = 7'b1100111;
      4'hA: on = 7'b1110111;
      4'hB: on = 7'b1111100;
      4'hC: on = 7'b0111001;
      4'hD: on = 7'b1011110;
      4'hE: on = 7'b1111001;
      default: on = 7'b1110001;
    endcase
    return ~on;
  endfunction

  assign step = en && (pre == PRE_LAST);

  // Ripple enable: a digit moves only while every lower digit sits at its
  // extreme; the enable surviving past the top digit is the full wrap.
  always_comb begin
    logic       prop;
    logic [3:0] dig;
    prop      = 1'b1;
    dig       = '0;
    count_nxt = count;
    for (int unsigned i = 0; i < ND; i++) begin
      dig = count[4*i +: 4];
      if (prop) begin
        if (updown) count_nxt[4*i +: 4] = (dig == DIG_MAX) ? 4'd0 : dig + 4'd1;
        else        count_nxt[4*i +: 4] = (dig == 4'd0) ? DIG_MAX : dig - 4'd1;
      end
      prop = prop && (updown ? (dig == DIG_MAX) : (dig == 4'd0));
    end
    wrap = prop;
  end

  always_comb begin
    load_fix = load_val;
    for (int unsigned i = 0; i < ND; i++) begin
      if (RADIX == 10 && load_val[4*i +: 4] > 4'd9) load_fix[4*i +: 4] = 4'd9;
    end
  end

  always_ff @(posedge ck or negedge reset) begin
    if (!reset) begin
      pre   <= '0;
      count <= '0;
      tick  <= 1'b0;
      carry <= 1'b0;
      seg   <= '1;
    end else begin
      tick  <= 1'b0;
      carry <= 1'b0;
      for (int unsigned i = 0; i < ND; i++) begin
        seg[7*i +: 7] <= seg_of(count[4*i +: 4]);
      end
      if (load) begin
        count <= load_fix;
        pre   <= '0;
      end else if (en) begin
        if (step) begin
          pre   <= '0;
          count <= count_nxt;
          tick  <= 1'b1;
          carry <= wrap;
        end else begin
          pre <= pre + 1'b1;
        end
      end
    end
  end

endmodule
